// File: rtl/balance_readout.sv
// Snapshots one player's 8-bit balance from the RAM word and shows it as three BCD digits plus the player index.
// Latency: 9 cycles from trigger to done (1 cycle for an out-of-range player). Outputs hold between done pulses.
// Backpressure: none; triggers arriving mid-conversion collapse into a single pending re-run.
module balance_readout #(
    parameter int NUM_PLAYERS   = 6,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [47:0] memory_values,
    input  logic        load_memory,
    input  logic [2:0]  player_sel,
    output logic [6:0]  hex_ones,
    output logic [6:0]  hex_tens,
    output logic [6:0]  hex_hund,
    output logic [6:0]  hex_player,
    output logic        busy,
    output logic        done,
    output logic        invalid
);

    typedef enum logic [1:0] {IDLE, CONVERT, PUBLISH} state_t;

    localparam logic [3:0] NP = 4'(NUM_PLAYERS);

    state_t      state;
    logic [2:0]  sel_q;
    logic [2:0]  sel_lat;
    logic [7:0]  bal;
    logic [11:0] bcd;
    logic [2:0]  count;
    logic        pending;
    logic        inv_path;

    logic        trigger;
    logic        sel_ok;
    logic        start;
    logic [63:0] mem_ext;
    logic [7:0]  slot_val;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic [3:0]  d_hund, d_tens, d_ones;
    logic        blank_h, blank_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign trigger  = load_memory | (player_sel != sel_q);
    assign sel_ok   = {1'b0, player_sel} < NP;
    assign start    = ((state == IDLE) && trigger) || ((state == PUBLISH) && (pending || trigger));
    // Zero-extended so the slot index never runs off the end of the 48-bit word.
    assign mem_ext  = {16'h0000, memory_values};
    assign slot_val = mem_ext[{player_sel, 3'b000} +: 8];

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bal} << 1;
    end

    assign d_hund  = bcd[11:8];
    assign d_tens  = bcd[7:4];
    assign d_ones  = bcd[3:0];
    assign blank_h = BLANK_LEADING && (d_hund == 4'd0);
    assign blank_t = blank_h && (d_tens == 4'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sel_q      <= 3'd0;
            sel_lat    <= 3'd0;
            bal        <= 8'd0;
            bcd        <= 12'd0;
            count      <= 3'd0;
            pending    <= 1'b0;
            inv_path   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            invalid    <= 1'b0;
            hex_ones   <= 7'h7F;
            hex_tens   <= 7'h7F;
            hex_hund   <= 7'h7F;
            hex_player <= 7'h7F;
        end else begin
            sel_q <= player_sel;
            done  <= 1'b0;
            case (state)
                CONVERT: begin
                    if (trigger)
                        pending <= 1'b1;
                    bcd   <= shifted[19:8];
                    bal   <= shifted[7:0];
                    count <= count + 3'd1;
                    if (count == 3'd7)
                        state <= PUBLISH;
                end
                PUBLISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                    state   <= IDLE;
                    if (inv_path) begin
                        invalid    <= 1'b1;
                        hex_ones   <= 7'h3F;
                        hex_tens   <= 7'h3F;
                        hex_hund   <= 7'h3F;
                        hex_player <= 7'h3F;
                    end else begin
                        invalid    <= 1'b0;
                        hex_ones   <= seg7(d_ones);
                        hex_tens   <= blank_t ? 7'h7F : seg7(d_tens);
                        hex_hund   <= blank_h ? 7'h7F : seg7(d_hund);
                        hex_player <= seg7({1'b0, sel_lat});
                    end
                end
                default: ;
            endcase
            // A start overrides the idle return above, including a re-run out of PUBLISH.
            if (start) begin
                sel_lat <= player_sel;
                if (sel_ok) begin
                    bal      <= slot_val;
                    bcd      <= 12'd0;
                    count    <= 3'd0;
                    busy     <= 1'b1;
                    inv_path <= 1'b0;
                    state    <= CONVERT;
                end else begin
                    inv_path <= 1'b1;
                    state    <= PUBLISH;
                end
            end
        end
    end

endmodule
